dispatch_queue: RTL and testbench
=================================

# dispatch_queue

Parametrised dispatch stage with an instruction buffer, for the tensor-core front end between fetch/decode and the issue-stage functional-unit status tables (FUSTs). It buffers up to DEPTH decoded instructions and dispatches at most one per cycle, in order, to one of NUM_FU functional-unit channels. An instruction leaves only when its target FUST row is free and its destination register has no outstanding write (WAW). It generalises the fixed three-table scalar/matrix/GEMM dispatch to N channels with queueing, a register pending table and flush/freeze control.

## Interface
- NUM_FU, 3: functional-unit channels (FUST tables); FU_W = $clog2(NUM_FU)
- DEPTH, 4: buffer entries, power of two ≥ 2; CNT_W = $clog2(DEPTH)+1
- NREGS, 32: architectural registers; REG_W = $clog2(NREGS)
- INSTR_W, 32: opaque instruction payload width
- Reset is synchronous and active-high (CLK, RST); one clock.
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- flush  in  1  discard all buffered instructions
- freeze  in  1  hold the stage: no enqueue, no dispatch
- fetch_valid  in  1  decoded instruction offered
- fetch_instr  in  INSTR_W  payload
- fetch_fu  in  FU_W  target channel; values ≥ NUM_FU are illegal
- fetch_rd  in  REG_W  destination register
- fetch_rd_en  in  1  instruction writes rd
- fetch_ready  out  1  buffer can accept (= !full)
- fu_busy  in  NUM_FU  FUST row occupied, per channel
- wb_valid  in  1  writeback completes
- wb_rd  in  REG_W  register written back
- n_fust_en  out  NUM_FU  one-hot dispatch strobe; all zero when idle
- n_fust_instr  out  INSTR_W  head payload
- n_fust_rd  out  REG_W  head rd
- n_fust_rd_en  out  1  head rd_en
- count  out  CNT_W  buffered entries

## Operation
- Circular buffer with head/tail pointers of CNT_W bits. The MSB distinguishes full from empty. The pointers wrap modulo DEPTH.
- Enqueue when fetch_valid && fetch_ready && !freeze && !flush. fetch_ready is 0 when count == DEPTH, even if the head dispatches in the same cycle.
- Pending table: NREGS bits. Register 0 is never set.
- Effective pending: eff[r] = pending[r] && !(wb_valid && wb_rd == r). Writeback is bypassed into the hazard check.
- Dispatch condition: count > 0, !freeze, !flush, !fu_busy[head.fu], and !(head.rd_en && eff[head.rd]).
- On dispatch:
  - n_fust_en[head.fu] = 1.
  - The head pointer advances.
  - If rd_en and rd ≠ 0, pending[rd] is set. This set wins over a same-cycle writeback clear of the same register.
- Writeback clears pending[wb_rd] unless the same cycle's dispatch sets it.
- Issue is strictly in order. A blocked head blocks all younger entries.
- Flush:
  - Sets head = tail and count = 0.
  - Flush has priority over freeze, enqueue and dispatch.
  - Pending bits are kept, because in-flight instructions still write back.
- Freeze: no pointer or buffer change. Writeback clears still apply.
- Illegal fetch_fu: the entry is treated as permanently blocked; no n_fust_en bit is driven. The bench flags this as an error.
- Reset values:
  - Pointers, count and all pending bits are 0.
  - fetch_ready = 1.
  - n_fust_en = 0.
  - n_fust_instr, n_fust_rd and n_fust_rd_en are 0 while count == 0.

## Timing
- Enqueue is registered. An entry written at edge N is at the head and dispatchable in cycle N+1. Minimum fetch-to-dispatch latency is 1 cycle.
- n_fust_* outputs are combinational from registered head state, fu_busy, wb_* and freeze/flush. The issue stage latches them at the next edge.
- Throughput: 1 dispatch per cycle when unblocked. Back-to-back dispatches to the same FU depend on fu_busy updating from the issue stage.
- A pending bit set at edge N blocks a dependent head from cycle N+1. A writeback in cycle M unblocks in cycle M itself.
- RST asserted mid-operation: at the next edge all state returns to its reset value. RST has priority over flush, freeze and every other input.

## Configuration
- DISPATCH_PERF_EN defined: adds outputs stall_struct_cnt, stall_waw_cnt and disp_cnt, each 16-bit and saturating at 0xFFFF.
  - stall_struct_cnt: cycles with count > 0 that are blocked by fu_busy.
  - stall_waw_cnt: cycles blocked only by WAW.
  - disp_cnt: dispatches.
  - Counters are cleared by RST, not by flush, and are held during freeze.
- DISPATCH_PERF_EN undefined: the ports and logic are absent and behaviour is otherwise identical.

## Test plan
- Reset, then enqueue 4 instructions to FU 0,1,2,0 with fu_busy = 0 and distinct rd → n_fust_en = 001, 010, 100, 001 on consecutive cycles, the first one cycle after the first accept. count returns to 0.
- Fill DEPTH = 4 with fu_busy = 3'b111 → fetch_ready = 0 and count = 4. The 5th offer is not accepted. Release fu_busy[0] → the head to FU 0 dispatches and fetch_ready = 1 the next cycle.
- WAW:
  - Dispatch rd = 5, then enqueue another rd = 5 → blocked, n_fust_en = 0.
  - Assert wb_valid with wb_rd = 5 → it dispatches in that same cycle and pending[5] remains 1.
  - Repeat the sequence with rd = 0 → no blocking.
- freeze asserted for 3 cycles with the head ready → no dispatch, no enqueue, count unchanged. A wb during the freeze clears pending. Dispatch resumes the cycle freeze drops.
- flush with 3 entries and fetch_valid high in the same cycle → count = 0, the new instruction is not accepted, pending bits are unchanged. Wrap test: 10 enqueue/dispatch cycles keep payloads in FIFO order.
- With DISPATCH_PERF_EN: 5 fu_busy-blocked cycles, 2 WAW-blocked cycles and 3 dispatches → stall_struct_cnt = 5, stall_waw_cnt = 2, disp_cnt = 3. A forced preload of 0xFFFF stays at 0xFFFF after another stall.

Source files
------------

// File: rtl/dispatch_queue.sv
// -----------------------------------------------------------------------------
// dispatch_queue
//
// In-order dispatch stage with a small instruction buffer. Decoded
// instructions from fetch/decode are queued (up to DEPTH entries). At most one
// instruction per cycle leaves the head of the queue toward one of NUM_FU
// functional-unit status tables (FUSTs). The head leaves only when its target
// FUST row is free and its destination register has no outstanding write
// (WAW hazard tracked in a per-register pending table).
//
// Parameters:
//   NUM_FU   number of functional-unit channels (>= 2)
//   DEPTH    buffer entries, power of two >= 2
//   NREGS    architectural registers (power of two)
//   INSTR_W  opaque payload width
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   flush          discard all buffered entries (pending table kept)
//   freeze         hold pointers and buffer; writebacks still clear pending
//   fetch_valid    instruction offered, with fetch_instr/fu/rd/rd_en
//   fetch_ready    buffer not full
//   fu_busy        per-channel FUST row occupied
//   wb_valid/wb_rd writeback completion, bypassed into the hazard check
//   n_fust_en      one-hot dispatch strobe (zero when nothing dispatches)
//   n_fust_instr/rd/rd_en  head entry fields (zero while the buffer is empty)
//   count          number of buffered entries
//
// Build option:
//   DISPATCH_PERF_EN  adds saturating 16-bit counters stall_struct_cnt,
//                     stall_waw_cnt and disp_cnt.
// -----------------------------------------------------------------------------
module dispatch_queue #(
  parameter int NUM_FU  = 3,
  parameter int DEPTH   = 4,
  parameter int NREGS   = 32,
  parameter int INSTR_W = 32,
  localparam int FU_W   = $clog2(NUM_FU),
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int REG_W  = $clog2(NREGS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  input  logic               freeze,
  input  logic               fetch_valid,
  input  logic [INSTR_W-1:0] fetch_instr,
  input  logic [FU_W-1:0]    fetch_fu,
  input  logic [REG_W-1:0]   fetch_rd,
  input  logic               fetch_rd_en,
  output logic               fetch_ready,
  input  logic [NUM_FU-1:0]  fu_busy,
  input  logic               wb_valid,
  input  logic [REG_W-1:0]   wb_rd,
  output logic [NUM_FU-1:0]  n_fust_en,
  output logic [INSTR_W-1:0] n_fust_instr,
  output logic [REG_W-1:0]   n_fust_rd,
  output logic               n_fust_rd_en,
  output logic [CNT_W-1:0]   count
`ifdef DISPATCH_PERF_EN
  ,
  output logic [15:0]        stall_struct_cnt,
  output logic [15:0]        stall_waw_cnt,
  output logic [15:0]        disp_cnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [FU_W-1:0]    fu_mem    [DEPTH];
  logic [REG_W-1:0]   rd_mem    [DEPTH];
  logic               rd_en_mem [DEPTH];

  // Pointers carry one extra bit so that head == tail means empty and
  // head/tail differing only in the MSB means full.
  logic [CNT_W-1:0] head_ptr;
  logic [CNT_W-1:0] tail_ptr;
  logic [NREGS-1:0] pending;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;

  assign head_idx = head_ptr[IDX_W-1:0];
  assign tail_idx = tail_ptr[IDX_W-1:0];

  // Modulo-2*DEPTH subtraction gives the occupancy directly.
  assign count       = tail_ptr - head_ptr;
  assign fetch_ready = (count != CNT_W'(DEPTH));

  logic nonempty;
  assign nonempty = (count != '0);

  // ---------------------------------------------------------------------------
  // Head decode and dispatch decision
  // ---------------------------------------------------------------------------
  logic [FU_W-1:0]  head_fu;
  logic [REG_W-1:0] head_rd;
  logic             head_rd_en;
  logic             fu_legal;
  logic             head_busy;
  logic             waw_block;
  logic             stage_active;
  logic             enqueue;
  logic             dispatch;

  assign head_fu    = fu_mem[head_idx];
  assign head_rd    = rd_mem[head_idx];
  assign head_rd_en = rd_en_mem[head_idx];

  // NOTE: every variable assigned in an always_comb gets a default before any
  // conditional assignment, otherwise the tool infers a latch.
  always_comb begin
    fu_legal  = 1'b0;
    head_busy = 1'b1;   // an illegal channel reads as permanently busy
    for (int i = 0; i < NUM_FU; i++) begin
      if (head_fu == FU_W'(i)) begin
        fu_legal  = 1'b1;
        head_busy = fu_busy[i];
      end
    end
  end

  // A writeback landing this cycle releases the hazard immediately.
  assign waw_block = head_rd_en && pending[head_rd] &&
                     !(wb_valid && (wb_rd == head_rd));

  // flush and freeze both silence enqueue and dispatch.
  assign stage_active = !freeze && !flush;
  assign enqueue      = fetch_valid && fetch_ready && stage_active;
  assign dispatch     = nonempty && stage_active && !head_busy && !waw_block;

  always_comb begin
    n_fust_en = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      n_fust_en[i] = dispatch && (head_fu == FU_W'(i));
    end
  end

  // Head fields are forced to zero while the buffer is empty so that stale
  // payloads never leak toward the issue stage.
  assign n_fust_instr = nonempty ? instr_mem[head_idx] : '0;
  assign n_fust_rd    = nonempty ? head_rd             : '0;
  assign n_fust_rd_en = nonempty ? head_rd_en          : 1'b0;

  // ---------------------------------------------------------------------------
  // Pointer and pending-table update
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      pending  <= '0;
    end else begin
      // Writeback clear first; a same-cycle dispatch set below overrides it.
      if (wb_valid) begin
        pending[wb_rd] <= 1'b0;
      end
      if (dispatch && head_rd_en && (head_rd != '0)) begin
        pending[head_rd] <= 1'b1;
      end

      if (flush) begin
        head_ptr <= tail_ptr;
      end else if (!freeze) begin
        if (enqueue) begin
          tail_ptr <= tail_ptr + CNT_W'(1);
        end
        if (dispatch) begin
          head_ptr <= head_ptr + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the payload array carries no reset; occupancy is tracked by the
  // pointers, and unoccupied slots are never observable on the outputs.
  always_ff @(posedge CLK) begin
    if (enqueue) begin
      instr_mem[tail_idx] <= fetch_instr;
      fu_mem[tail_idx]    <= fetch_fu;
      rd_mem[tail_idx]    <= fetch_rd;
      rd_en_mem[tail_idx] <= fetch_rd_en;
    end
  end

`ifdef DISPATCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating, cleared only by RST)
  // ---------------------------------------------------------------------------
  logic struct_stall;
  logic waw_stall;

  // Structural stall: a legal head waiting on its FUST row. WAW stall: the
  // row is free and only the register hazard holds the head.
  assign struct_stall = nonempty && stage_active && fu_legal && head_busy;
  assign waw_stall    = nonempty && stage_active && !head_busy && waw_block;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_struct_cnt <= '0;
      stall_waw_cnt    <= '0;
      disp_cnt         <= '0;
    end else begin
      if (struct_stall && (stall_struct_cnt != 16'hFFFF)) begin
        stall_struct_cnt <= stall_struct_cnt + 16'd1;
      end
      if (waw_stall && (stall_waw_cnt != 16'hFFFF)) begin
        stall_waw_cnt <= stall_waw_cnt + 16'd1;
      end
      if (dispatch && (disp_cnt != 16'hFFFF)) begin
        disp_cnt <= disp_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_dispatch_queue
//
// Self-checking bench for dispatch_queue (default parameters). Every accepted
// instruction is pushed to a scoreboard when it is offered; a negedge monitor
// pops and compares it whenever the DUT raises a dispatch strobe. Directed
// sequences check timing, blocking, freeze, flush, reset and (with
// DISPATCH_PERF_EN) the performance counters.
// -----------------------------------------------------------------------------
module tb_dispatch_queue;

  localparam int NUM_FU  = 3;
  localparam int DEPTH   = 4;
  localparam int NREGS   = 32;
  localparam int INSTR_W = 32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        freeze;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [1:0]  fetch_fu;
  logic [4:0]  fetch_rd;
  logic        fetch_rd_en;
  logic        fetch_ready;
  logic [2:0]  fu_busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [2:0]  n_fust_en;
  logic [31:0] n_fust_instr;
  logic [4:0]  n_fust_rd;
  logic        n_fust_rd_en;
  logic [2:0]  count;
`ifdef DISPATCH_PERF_EN
  logic [15:0] stall_struct_cnt;
  logic [15:0] stall_waw_cnt;
  logic [15:0] disp_cnt;
`endif

  dispatch_queue #(
    .NUM_FU (NUM_FU),
    .DEPTH  (DEPTH),
    .NREGS  (NREGS),
    .INSTR_W(INSTR_W)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .flush       (flush),
    .freeze      (freeze),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fu    (fetch_fu),
    .fetch_rd    (fetch_rd),
    .fetch_rd_en (fetch_rd_en),
    .fetch_ready (fetch_ready),
    .fu_busy     (fu_busy),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .n_fust_en   (n_fust_en),
    .n_fust_instr(n_fust_instr),
    .n_fust_rd   (n_fust_rd),
    .n_fust_rd_en(n_fust_rd_en),
    .count       (count)
`ifdef DISPATCH_PERF_EN
    ,
    .stall_struct_cnt(stall_struct_cnt),
    .stall_waw_cnt   (stall_waw_cnt),
    .disp_cnt        (disp_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  fu;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        rd_en;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Scoreboard monitor: every dispatch must match the oldest accepted entry.
  always @(negedge CLK) begin
    if (!RST && (n_fust_en != 3'b000)) begin
      if (sb.size() == 0) begin
        check("disp_unexpected", 64'(n_fust_en), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("disp_en",    64'(n_fust_en),    64'(3'b001 << mon_e.fu));
        check("disp_instr", 64'(n_fust_instr), 64'(mon_e.instr));
        check("disp_rd",    64'(n_fust_rd),    64'(mon_e.rd));
        check("disp_rd_en", 64'(n_fust_rd_en), 64'(mon_e.rd_en));
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic offer(input logic [1:0] fu, input logic [4:0] rd, input logic rd_en,
                       input logic [31:0] instr, input bit accept);
    fetch_valid = 1'b1;
    fetch_fu    = fu;
    fetch_rd    = rd;
    fetch_rd_en = rd_en;
    fetch_instr = instr;
    if (accept) sb.push_back('{fu, instr, rd, rd_en});
  endtask

  task automatic idle();
    fetch_valid = 1'b0;
  endtask

  task automatic wb_pulse(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd    = r;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    idle();
    fu_busy = 3'b000;
    for (int i = 0; i < 20 && count != 3'd0; i++) step();
    at_neg();
    check(tag, 64'(count), 64'd0);
    step();
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; freeze = 1'b0;
    fetch_valid = 1'b0; fetch_instr = '0; fetch_fu = '0; fetch_rd = '0; fetch_rd_en = 1'b0;
    fu_busy = 3'b000; wb_valid = 1'b0; wb_rd = '0;
    step(); step();
    RST = 1'b0;

    // Reset state
    at_neg();
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(fetch_ready), 64'd1);
    check("rst_en",    64'(n_fust_en), 64'd0);
    check("rst_instr", 64'(n_fust_instr), 64'd0);
    check("rst_rd",    64'(n_fust_rd), 64'd0);
    check("rst_rd_en", 64'(n_fust_rd_en), 64'd0);
    step();

    // Back-to-back dispatch to FU 0,1,2,0, first strobe one cycle after accept
    offer(2'd0, 5'd1, 1'b1, 32'h1111_0000, 1); step();
    offer(2'd1, 5'd2, 1'b1, 32'h1111_0001, 1); at_neg(); check("t1_d0", 64'(n_fust_en), 64'b001); step();
    offer(2'd2, 5'd3, 1'b1, 32'h1111_0002, 1); at_neg(); check("t1_d1", 64'(n_fust_en), 64'b010); step();
    offer(2'd0, 5'd4, 1'b1, 32'h1111_0003, 1); at_neg(); check("t1_d2", 64'(n_fust_en), 64'b100); step();
    idle(); at_neg(); check("t1_d3", 64'(n_fust_en), 64'b001); step();
    at_neg();
    check("t1_count", 64'(count), 64'd0);
    check("t1_idle",  64'(n_fust_en), 64'd0);
    step();
    for (int r = 1; r <= 4; r++) wb_pulse(5'(r));

    // Fill with all FUs busy, fifth offer refused, release FU 0
    fu_busy = 3'b111;
    offer(2'd0, 5'd0, 1'b0, 32'h2222_0000, 1); step();
    offer(2'd1, 5'd0, 1'b0, 32'h2222_0001, 1); step();
    offer(2'd2, 5'd0, 1'b0, 32'h2222_0002, 1); step();
    offer(2'd0, 5'd0, 1'b0, 32'h2222_0003, 1); step();
    offer(2'd1, 5'd0, 1'b0, 32'h2222_0004, 0);
    at_neg();
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(fetch_ready), 64'd0);
    step();
    idle(); fu_busy = 3'b110;
    at_neg();
    check("full_fifth_refused", 64'(count), 64'd4);
    check("full_release_en",    64'(n_fust_en), 64'b001);
    check("full_ready_same",    64'(fetch_ready), 64'd0);
    step();
    at_neg();
    check("full_ready_next", 64'(fetch_ready), 64'd1);
    check("full_count_next", 64'(count), 64'd3);
    step();
    drain("full_drain");

    // WAW blocking and same-cycle writeback bypass
    offer(2'd0, 5'd5, 1'b1, 32'h3333_0000, 1); step();
    offer(2'd1, 5'd5, 1'b1, 32'h3333_0001, 1); step();
    idle(); at_neg(); check("waw_blk0", 64'(n_fust_en), 64'd0); step();
    at_neg(); check("waw_blk1", 64'(n_fust_en), 64'd0); step();
    wb_valid = 1'b1; wb_rd = 5'd5;
    at_neg(); check("waw_bypass", 64'(n_fust_en), 64'b010); step();
    wb_valid = 1'b0;
    offer(2'd2, 5'd5, 1'b1, 32'h3333_0002, 1); step();
    idle(); at_neg(); check("waw_set_wins", 64'(n_fust_en), 64'd0); step();
    wb_valid = 1'b1; wb_rd = 5'd5;
    at_neg(); check("waw_bypass2", 64'(n_fust_en), 64'b100); step();
    wb_valid = 1'b0;
    wb_pulse(5'd5);
    offer(2'd0, 5'd0, 1'b1, 32'h3333_0010, 1); step();
    offer(2'd1, 5'd0, 1'b1, 32'h3333_0011, 1); at_neg(); check("rd0_first", 64'(n_fust_en), 64'b001); step();
    idle(); at_neg(); check("rd0_noblock", 64'(n_fust_en), 64'b010); step();

    // Freeze for 3 cycles with a ready head; writeback still clears
    offer(2'd0, 5'd7, 1'b1, 32'h4444_0000, 1); step();
    idle(); step();
    offer(2'd1, 5'd8, 1'b1, 32'h4444_0001, 1); step();
    freeze = 1'b1;
    offer(2'd2, 5'd0, 1'b0, 32'h4444_0002, 0);
    at_neg(); check("frz_en0", 64'(n_fust_en), 64'd0); check("frz_cnt0", 64'(count), 64'd1); step();
    wb_valid = 1'b1; wb_rd = 5'd7;
    at_neg(); check("frz_en1", 64'(n_fust_en), 64'd0); step();
    wb_valid = 1'b0;
    at_neg(); check("frz_en2", 64'(n_fust_en), 64'd0); check("frz_cnt2", 64'(count), 64'd1); step();
    freeze = 1'b0; idle();
    at_neg(); check("frz_resume", 64'(n_fust_en), 64'b010); step();
    offer(2'd0, 5'd7, 1'b1, 32'h4444_0003, 1); step();
    idle(); at_neg(); check("frz_wb_cleared", 64'(n_fust_en), 64'b001); step();
    wb_pulse(5'd7); wb_pulse(5'd8);

    // Flush with 3 entries and a simultaneous offer; pending survives
    offer(2'd0, 5'd9, 1'b1, 32'h5555_0000, 1); step();
    idle(); step();
    fu_busy = 3'b111;
    offer(2'd0, 5'd0, 1'b0, 32'h5555_0001, 1); step();
    offer(2'd1, 5'd0, 1'b0, 32'h5555_0002, 1); step();
    offer(2'd2, 5'd0, 1'b0, 32'h5555_0003, 1); step();
    idle();
    at_neg(); check("fl_pre_count", 64'(count), 64'd3);
    flush = 1'b1;
    offer(2'd1, 5'd0, 1'b0, 32'h5555_0004, 0);
    step();
    flush = 1'b0; idle(); sb.delete();
    at_neg();
    check("fl_count", 64'(count), 64'd0);
    check("fl_ready", 64'(fetch_ready), 64'd1);
    check("fl_en",    64'(n_fust_en), 64'd0);
    step();
    fu_busy = 3'b000;
    offer(2'd0, 5'd9, 1'b1, 32'h5555_0005, 1); step();
    idle(); at_neg(); check("fl_pend_kept", 64'(n_fust_en), 64'd0); step();
    wb_valid = 1'b1; wb_rd = 5'd9;
    at_neg(); check("fl_wb_release", 64'(n_fust_en), 64'b001); step();
    wb_valid = 1'b0;
    wb_pulse(5'd9);

    // Illegal channel: permanently blocked, no strobe
    offer(2'd3, 5'd0, 1'b0, 32'h6666_0000, 0); step();
    idle();
    at_neg(); check("ill_en0", 64'(n_fust_en), 64'd0); check("ill_cnt", 64'(count), 64'd1); step();
    at_neg(); check("ill_en1", 64'(n_fust_en), 64'd0);
    flush = 1'b1; step(); flush = 1'b0;
    at_neg(); check("ill_flushed", 64'(count), 64'd0); step();

    // Wrap: 10 consecutive enqueue/dispatch cycles, FIFO order via scoreboard
    for (int i = 0; i < 10; i++) begin
      offer(2'(i % 3), 5'd0, 1'b0, $urandom, 1);
      step();
    end
    drain("wrap_drain");

    // Reset mid-operation beats flush/freeze and clears pending
    offer(2'd0, 5'd11, 1'b1, 32'h7777_0000, 1); step();
    idle(); step();
    fu_busy = 3'b111;
    offer(2'd1, 5'd0, 1'b0, 32'h7777_0001, 1); step();
    offer(2'd2, 5'd0, 1'b0, 32'h7777_0002, 1); step();
    idle();
    RST = 1'b1; flush = 1'b1; freeze = 1'b1;
    step();
    RST = 1'b0; flush = 1'b0; freeze = 1'b0; sb.delete();
    at_neg();
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_ready", 64'(fetch_ready), 64'd1);
    check("mrst_en",    64'(n_fust_en), 64'd0);
    check("mrst_instr", 64'(n_fust_instr), 64'd0);
    step();
    fu_busy = 3'b000;
    offer(2'd0, 5'd11, 1'b1, 32'h7777_0003, 1); step();
    idle(); at_neg(); check("mrst_pend_clr", 64'(n_fust_en), 64'b001); step();
    wb_pulse(5'd11);

`ifdef DISPATCH_PERF_EN
    // Counters: 5 structural stalls, 2 WAW stalls, 3 dispatches
    RST = 1'b1; step(); RST = 1'b0;
    fu_busy = 3'b111;
    offer(2'd0, 5'd10, 1'b1, 32'h8888_0000, 1); step();
    idle();
    repeat (5) step();
    fu_busy = 3'b000;
    offer(2'd1, 5'd10, 1'b1, 32'h8888_0001, 1); step();
    idle(); step(); step();
    wb_valid = 1'b1; wb_rd = 5'd10; step(); wb_valid = 1'b0;
    offer(2'd2, 5'd0, 1'b0, 32'h8888_0002, 1); step();
    idle(); step();
    at_neg();
    check("perf_struct", 64'(stall_struct_cnt), 64'd5);
    check("perf_waw",    64'(stall_waw_cnt), 64'd2);
    check("perf_disp",   64'(disp_cnt), 64'd3);
    step();
    fu_busy = 3'b111;
    offer(2'd0, 5'd0, 1'b0, 32'h8888_0003, 0); step();
    idle();
    repeat (65540) step();
    at_neg(); check("perf_sat", 64'(stall_struct_cnt), 64'hFFFF);
    step();
    flush = 1'b1; step(); flush = 1'b0; fu_busy = 3'b000;
    wb_pulse(5'd10);
`endif

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
